// File: rtl/smoldvi_pkg.sv
// Purpose: shared phase encoding and default 640x480 timing for the smoldvi timing path.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: phase_t (FRONT/SYNC/BACK/ACTIVE, shared by both axes), DEF_* 640x480 lengths,
//           next_phase() giving the fixed phase rotation.
package smoldvi_pkg;

   typedef enum logic [1:0] {
      PH_FRONT  = 2'd0,
      PH_SYNC   = 2'd1,
      PH_BACK   = 2'd2,
      PH_ACTIVE = 2'd3
   } phase_t;

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;
   localparam int DEF_V_ACTIVE = 480;

   function automatic phase_t next_phase(input phase_t p);
      case (p)
         PH_FRONT: return PH_SYNC;
         PH_SYNC:  return PH_BACK;
         PH_BACK:  return PH_ACTIVE;
         default:  return PH_FRONT;
      endcase
   endfunction

endpackage

// File: rtl/smoldvi_phase_counter.sv
// Purpose: one timing axis: phase state plus an in-phase position counter, FRONT->SYNC->BACK->ACTIVE.
// Latency: phase/first/last describe the current cycle; state updates on the next clk edge.
// Backpressure: none; advances whenever adv is high, clr overrides and parks at FRONT position 0.
// Ports: clk, rst (async, active-high), clr (sync park), adv (advance one step),
//        len_* (phase lengths, 0 treated as 1), phase (current phase), first (FRONT position 0),
//        last (final cycle of the current phase).
module smoldvi_phase_counter
   import smoldvi_pkg::*;
#(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         adv,
   input  logic [W-1:0] len_front,
   input  logic [W-1:0] len_sync,
   input  logic [W-1:0] len_back,
   input  logic [W-1:0] len_active,
   output logic [1:0]   phase,
   output logic         first,
   output logic         last
);

   localparam logic [W-1:0] ONE = W'(1);

   phase_t       state, state_nxt;
   logic [W-1:0] cnt, cnt_nxt;
   logic [W-1:0] cur_len, end_cnt;
   logic         at_end;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= PH_FRONT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next state: the counter restarts from 0 on every phase change, so it can never wrap
   always_comb begin
      cur_len = len_front;
      case (state)
         PH_FRONT:  cur_len = len_front;
         PH_SYNC:   cur_len = len_sync;
         PH_BACK:   cur_len = len_back;
         default:   cur_len = len_active;
      endcase
      // a zero length behaves as a one-cycle phase
      end_cnt   = (cur_len == '0) ? '0 : cur_len - ONE;
      at_end    = (cnt == end_cnt);
      state_nxt = state;
      cnt_nxt   = cnt;
      if (clr) begin
         state_nxt = PH_FRONT;
         cnt_nxt   = '0;
      end else if (adv) begin
         if (at_end) begin
            state_nxt = next_phase(state);
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + ONE;
         end
      end
   end

   // outputs
   always_comb begin
      phase = state;
      first = (state == PH_FRONT) && (cnt == '0);
      last  = at_end;
   end

endmodule

// File: rtl/smoldvi_timing_ctrl.sv
// Purpose: DVI raster timing: H/V phase FSMs, registered sync/den, pixel handshake and markers.
// Latency: hsync/vsync/den one cycle after the FSM state; pix_ready, line_start, frame_start same cycle.
// Backpressure: never stalls; a missing pixel (pix_valid low while required) sets sticky underflow.
// Ports: clk_pix, rst_pix (async active-high), en (low parks at frame start and clears outputs),
//        h_*/v_* phase lengths (sampled at frame_start), pix_valid/pix_ready, hsync, vsync, den,
//        line_start, frame_start, underflow.
module smoldvi_timing_ctrl
   import smoldvi_pkg::*;
#(
   parameter int W_H       = 12,
   parameter int W_V       = 11,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0
) (
   input  logic           clk_pix,
   input  logic           rst_pix,
   input  logic           en,
   input  logic [W_H-1:0] h_front,
   input  logic [W_H-1:0] h_sync,
   input  logic [W_H-1:0] h_back,
   input  logic [W_H-1:0] h_active,
   input  logic [W_V-1:0] v_front,
   input  logic [W_V-1:0] v_sync,
   input  logic [W_V-1:0] v_back,
   input  logic [W_V-1:0] v_active,
   input  logic           pix_valid,
   output logic           pix_ready,
   output logic           hsync,
   output logic           vsync,
   output logic           den,
   output logic           line_start,
   output logic           frame_start,
   output logic           underflow
);

   logic [W_H-1:0] sh_h_front, sh_h_sync, sh_h_back, sh_h_active;
   logic [W_V-1:0] sh_v_front, sh_v_sync, sh_v_back, sh_v_active;
   logic [W_H-1:0] eff_h_front, eff_h_sync, eff_h_back, eff_h_active;
   logic [W_V-1:0] eff_v_front, eff_v_sync, eff_v_back, eff_v_active;

   logic [1:0] h_phase, v_phase;
   logic       h_first, h_last, v_first, v_last;
   logic       line_pt, frame_pt, den_cond, v_adv;
   // end-of-frame flag of the vertical axis is not needed by this block
   logic       unused_v_last;

   assign unused_v_last = v_last;

   // markers are gated by rst_pix so they read 0 while reset is held
   assign line_pt  = en && !rst_pix && h_first;
   assign frame_pt = line_pt && v_first;
   assign den_cond = en && !rst_pix && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
   assign v_adv    = en && (h_phase == PH_ACTIVE) && h_last;

   // On the frame_start cycle the shadows are still being loaded, so the live inputs
   // govern that cycle; this keeps the first phase of the frame at its new length.
   assign eff_h_front  = frame_pt ? h_front  : sh_h_front;
   assign eff_h_sync   = frame_pt ? h_sync   : sh_h_sync;
   assign eff_h_back   = frame_pt ? h_back   : sh_h_back;
   assign eff_h_active = frame_pt ? h_active : sh_h_active;
   assign eff_v_front  = frame_pt ? v_front  : sh_v_front;
   assign eff_v_sync   = frame_pt ? v_sync   : sh_v_sync;
   assign eff_v_back   = frame_pt ? v_back   : sh_v_back;
   assign eff_v_active = frame_pt ? v_active : sh_v_active;

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         sh_h_front  <= '0;
         sh_h_sync   <= '0;
         sh_h_back   <= '0;
         sh_h_active <= '0;
         sh_v_front  <= '0;
         sh_v_sync   <= '0;
         sh_v_back   <= '0;
         sh_v_active <= '0;
      end else if (frame_pt) begin
         sh_h_front  <= h_front;
         sh_h_sync   <= h_sync;
         sh_h_back   <= h_back;
         sh_h_active <= h_active;
         sh_v_front  <= v_front;
         sh_v_sync   <= v_sync;
         sh_v_back   <= v_back;
         sh_v_active <= v_active;
      end
   end

   smoldvi_phase_counter #(.W(W_H)) u_h_axis (
      .clk        (clk_pix),
      .rst        (rst_pix),
      .clr        (!en),
      .adv        (1'b1),
      .len_front  (eff_h_front),
      .len_sync   (eff_h_sync),
      .len_back   (eff_h_back),
      .len_active (eff_h_active),
      .phase      (h_phase),
      .first      (h_first),
      .last       (h_last)
   );

   // one vertical step per line, taken on the last H_ACTIVE cycle
   smoldvi_phase_counter #(.W(W_V)) u_v_axis (
      .clk        (clk_pix),
      .rst        (rst_pix),
      .clr        (!en),
      .adv        (v_adv),
      .len_front  (eff_v_front),
      .len_sync   (eff_v_sync),
      .len_back   (eff_v_back),
      .len_active (eff_v_active),
      .phase      (v_phase),
      .first      (v_first),
      .last       (v_last)
   );

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         hsync     <= !HSYNC_POL;
         vsync     <= !VSYNC_POL;
         den       <= 1'b0;
         underflow <= 1'b0;
      end else if (!en) begin
         hsync     <= !HSYNC_POL;
         vsync     <= !VSYNC_POL;
         den       <= 1'b0;
         underflow <= 1'b0;
      end else begin
         hsync <= (h_phase == PH_SYNC) ? HSYNC_POL : !HSYNC_POL;
         vsync <= (v_phase == PH_SYNC) ? VSYNC_POL : !VSYNC_POL;
         den   <= den_cond;
         if (den_cond && !pix_valid) begin
            underflow <= 1'b1;
         end
      end
   end

   assign pix_ready   = den_cond && pix_valid;
   assign line_start  = line_pt;
   assign frame_start = frame_pt;

endmodule

// File: tb/tb_smoldvi_timing_ctrl.sv
// Purpose: self-checking bench for smoldvi_timing_ctrl against a raster-position reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_smoldvi_timing_ctrl;
   import smoldvi_pkg::*;

   localparam int WH = 12;
   localparam int WV = 11;
   localparam bit HP = 1'b1;
   localparam bit VP = 1'b0;

   logic          clk_pix = 1'b0;
   logic          rst_pix;
   logic          en;
   logic          pix_valid;
   logic [WH-1:0] h_front, h_sync, h_back, h_active;
   logic [WV-1:0] v_front, v_sync, v_back, v_active;
   logic          pix_ready, hsync, vsync, den, line_start, frame_start, underflow;

   smoldvi_timing_ctrl #(.W_H(WH), .W_V(WV), .HSYNC_POL(HP), .VSYNC_POL(VP)) dut (
      .clk_pix     (clk_pix),
      .rst_pix     (rst_pix),
      .en          (en),
      .h_front     (h_front),
      .h_sync      (h_sync),
      .h_back      (h_back),
      .h_active    (h_active),
      .v_front     (v_front),
      .v_sync      (v_sync),
      .v_back      (v_back),
      .v_active    (v_active),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .hsync       (hsync),
      .vsync       (vsync),
      .den         (den),
      .line_start  (line_start),
      .frame_start (frame_start),
      .underflow   (underflow)
   );

   always #5 clk_pix = ~clk_pix;

   int n_checks = 0;
   int n_fail   = 0;

   // event counters for whole-frame properties
   int cnt_pr = 0, cnt_hs = 0, cnt_ls = 0, cnt_fs = 0;
   always @(negedge clk_pix) begin
      if (pix_ready === 1'b1)   cnt_pr++;
      if (hsync === HP)         cnt_hs++;
      if (line_start === 1'b1)  cnt_ls++;
      if (frame_start === 1'b1) cnt_fs++;
   end

   // reference model: raster position (x within line, y within frame) and a per-frame config snapshot
   int mx, my;
   int c_hf, c_hs, c_hb, c_ha, c_vf, c_vs, c_vb, c_va;
   bit m_hs, m_vs, m_den, m_uf;

   function automatic int len1(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic bit model_dc();
      return (mx >= c_hf + c_hs + c_hb) && (my >= c_vf + c_vs + c_vb);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mx = 0; my = 0;
      c_hf = 1; c_hs = 1; c_hb = 1; c_ha = 1;
      c_vf = 1; c_vs = 1; c_vb = 1; c_va = 1;
      m_hs = !HP; m_vs = !VP; m_den = 1'b0; m_uf = 1'b0;
   endtask

   task automatic set_cfg(input int hf, input int hs, input int hb, input int ha,
                          input int vf, input int vs, input int vb, input int va);
      h_front = WH'(hf); h_sync = WH'(hs); h_back = WH'(hb); h_active = WH'(ha);
      v_front = WV'(vf); v_sync = WV'(vs); v_back = WV'(vb); v_active = WV'(va);
   endtask

   task automatic zero_cnt();
      cnt_pr = 0; cnt_hs = 0; cnt_ls = 0; cnt_fs = 0;
   endtask

   // One pixel cycle: called just after a rising edge, drives inputs, checks at the falling edge,
   // advances the model, and returns just after the next rising edge.
   task automatic step(input bit en_i, input bit pv_i);
      bit ls, fs, dc, hs_c, vs_c;
      en = en_i;
      pix_valid = pv_i;
      @(negedge clk_pix);
      ls = 1'b0; fs = 1'b0; dc = 1'b0; hs_c = 1'b0; vs_c = 1'b0;
      if (en_i) begin
         ls = (mx == 0);
         fs = ls && (my == 0);
         if (fs) begin
            c_hf = len1(int'(h_front)); c_hs = len1(int'(h_sync));
            c_hb = len1(int'(h_back));  c_ha = len1(int'(h_active));
            c_vf = len1(int'(v_front)); c_vs = len1(int'(v_sync));
            c_vb = len1(int'(v_back));  c_va = len1(int'(v_active));
         end
         dc   = model_dc();
         hs_c = (mx >= c_hf) && (mx < c_hf + c_hs);
         vs_c = (my >= c_vf) && (my < c_vf + c_vs);
      end
      check("line_start",  line_start,  ls);
      check("frame_start", frame_start, fs);
      check("pix_ready",   pix_ready,   dc && pv_i);
      check("hsync",       hsync,       m_hs);
      check("vsync",       vsync,       m_vs);
      check("den",         den,         m_den);
      check("underflow",   underflow,   m_uf);
      if (en_i) begin
         m_hs  = hs_c ? HP : !HP;
         m_vs  = vs_c ? VP : !VP;
         m_den = dc;
         if (dc && !pv_i) m_uf = 1'b1;
         mx++;
         if (mx == c_hf + c_hs + c_hb + c_ha) begin
            mx = 0;
            my++;
            if (my == c_vf + c_vs + c_vb + c_va) my = 0;
         end
      end else begin
         mx = 0; my = 0;
         m_hs = !HP; m_vs = !VP; m_den = 1'b0; m_uf = 1'b0;
      end
      @(posedge clk_pix);
      #1;
   endtask

   // asserts reset between edges; outputs must drop at once, not at the next edge
   task automatic do_reset();
      rst_pix = 1'b1;
      #1;
      check("rst_hsync",       hsync,       !HP);
      check("rst_vsync",       vsync,       !VP);
      check("rst_den",         den,         1'b0);
      check("rst_pix_ready",   pix_ready,   1'b0);
      check("rst_line_start",  line_start,  1'b0);
      check("rst_frame_start", frame_start, 1'b0);
      check("rst_underflow",   underflow,   1'b0);
      model_reset();
      @(posedge clk_pix);
      #1;
      rst_pix = 1'b0;
   endtask

   initial begin
      int guard;
      rst_pix = 1'b0;
      en = 1'b0;
      pix_valid = 1'b1;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk_pix);
      #1;
      do_reset();
      step(0, 1);

      // 640-pixel line timing with a short vertical: 5 lines of 800 cycles
      set_cfg(DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK, DEF_H_ACTIVE, 0, 0, 0, 2);
      zero_cnt();
      repeat (4000) step(1, 1);
      check("vga_lines_per_frame", cnt_ls, 5);
      check("vga_frames",          cnt_fs, 1);
      check("vga_pixels",          cnt_pr, 2 * 640);
      check("vga_hsync_cycles",    cnt_hs, 5 * 96);

      // all lengths zero: 4x4 raster with a single active cycle
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1);
      zero_cnt();
      repeat (32) step(1, 1);
      check("zero_lines",  cnt_ls, 8);
      check("zero_frames", cnt_fs, 2);
      check("zero_pixels", cnt_pr, 2);

      // single missing pixel: sticky until en drops
      set_cfg(2, 2, 2, 4, 1, 1, 1, 2);
      step(0, 1);
      step(1, 1);
      guard = 0;
      while (!model_dc() && guard < 1000) begin
         step(1, 1);
         guard++;
      end
      check("uf_reach_active_timeout", guard < 1000, 1'b1);
      step(1, 0);
      repeat (30) step(1, 1);
      check("uf_sticky", underflow, 1'b1);
      step(0, 1);
      step(1, 1);
      check("uf_cleared", underflow, 1'b0);

      // mid-frame h_active change only applies from the next frame
      set_cfg(2, 2, 2, 8, 0, 0, 0, 2);
      step(0, 1);
      zero_cnt();
      repeat (20) step(1, 1);
      h_active = WH'(4);
      repeat (50) step(1, 1);
      check("cfg_old_frame_pixels", cnt_pr, 16);
      zero_cnt();
      repeat (50) step(1, 1);
      check("cfg_new_frame_pixels", cnt_pr, 8);

      // reset mid-line, then restart
      repeat (7) step(1, 1);
      do_reset();
      zero_cnt();
      step(1, 1);
      check("fs_after_reset", cnt_fs, 1);

      // randomized configs, pixel gaps, enable drops, resets and mid-frame config changes
      for (int seg = 0; seg < 180; seg++) begin
         set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         step(0, 1);
         for (int k = 0; k < 100; k++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 4) begin
               do_reset();
            end else if (r < 14) begin
               step(0, 1);
            end else begin
               if (r < 40) begin
                  h_active = WH'($urandom_range(0, 6));
                  v_back   = WV'($urandom_range(0, 3));
               end
               step(1, $urandom_range(0, 9) != 0);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
